// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr+rw, one data byte, ACKs, STOP) behind a valid/ready command port
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl,
  inout  wire        sda
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_AACK  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DACK  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [7:0] qcnt_q, qcnt_d, sh_q, sh_d, wd_q, wd_d, rdata_q, rdata_d;
  logic [1:0] phase_q, phase_d;
  logic       rw_q, rw_d, samp_q, samp_d, nerr_q, nerr_d, done_q, done_d, nack_q, nack_d;
  logic       qend, bend, accept, sda_low;
  assign qend      = qcnt_q == 8'(CLK_DIV - 1);
  assign bend      = qend && phase_q == 2'd3;
  assign cmd_ready = state_q == S_IDLE;
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = done_q;
  assign nack      = nack_q;
  assign rdata     = rdata_q;
  assign sda       = sda_low ? 1'b0 : 1'bz;
  // Bus pins decoded from state and quarter phase so an async reset releases them at once
  always_comb begin
    scl     = (state_q == S_IDLE || state_q == S_START) ? 1'b1 :
              state_q == S_STOP ? phase_q != 2'd0 : phase_q[1];
    sda_low = state_q == S_START ? phase_q[1] :
              state_q == S_STOP ? !phase_q[1] :
              (state_q == S_ADDR || (state_q == S_DATA && !rw_q)) ? !sh_q[7] : 1'b0;
  end
  // Quarter/phase timing, bit shifting and transaction sequencing
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    nerr_d  = nerr_q;
    nack_d  = nack_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    qcnt_d  = (state_q == S_IDLE || qend) ? 8'd0 : qcnt_q + 8'd1;
    phase_d = state_q == S_IDLE ? 2'd0 : qend ? phase_q + 2'd1 : phase_q;
    samp_d  = (qend && phase_q == 2'd2) ? sda : samp_q;
    if (accept) begin
      state_d = S_START;
      sh_d    = {cmd_addr, cmd_rw};
      wd_d    = cmd_wdata;
      rw_d    = cmd_rw;
      bit_d   = 3'd7;
      nerr_d  = 1'b0;
      nack_d  = 1'b0;
    end else if (bend) begin
      case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR, S_DATA: begin
          sh_d    = {sh_q[6:0], samp_q};
          bit_d   = bit_q - 3'd1;
          state_d = bit_q != 3'd0 ? state_q : state_q == S_ADDR ? S_AACK : S_DACK;
        end
        S_AACK: begin
          state_d = samp_q ? S_STOP : S_DATA;
          nerr_d  = samp_q;
          sh_d    = wd_q;
        end
        S_DACK: begin
          state_d = S_STOP;
          nerr_d  = !rw_q && samp_q;
        end
        S_STOP: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          nack_d  = nerr_q;
          rdata_d = (rw_q && !nerr_q) ? sh_q : rdata_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // State registers with asynchronous reset to an idle, released bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      qcnt_q  <= 8'd0;
      phase_q <= 2'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      wd_q    <= 8'd0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b0;
      nerr_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wd_q    <= wd_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      nerr_q  <= nerr_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: scoreboard bench with a bus-decoding slave model for two divider settings
module tb_i2c_master_ctrl;
  typedef struct {
    int          inst;
    logic        nack;
    logic [7:0]  rdata;
    int          lat;
    int          cnt;
    logic [18:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      c_valid = '0, c_rw = '0;
  logic [1:0][6:0] c_addr = '0;
  logic [1:0][7:0] c_wd = '0;
  logic [1:0]      ready_v, busy_v, done_v, nack_v, scl_v, sda_v;
  logic [1:0][7:0] rdata_v;
  logic [1:0]      slv_drv = '0, slv_ack = '0, slv_rw = '0;
  logic [1:0][7:0] slv_data = '0;
  logic            acc_done = 1'b0;
  wire             sda0, sda1;

  pullup (sda0);
  pullup (sda1);
  assign sda0  = slv_drv[0] ? 1'b0 : 1'bz;
  assign sda1  = slv_drv[1] ? 1'b0 : 1'bz;
  assign sda_v = {sda1, sda0};

  i2c_master_ctrl #(.CLK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(c_valid[0]), .cmd_ready(ready_v[0]),
    .cmd_addr(c_addr[0]), .cmd_rw(c_rw[0]), .cmd_wdata(c_wd[0]), .busy(busy_v[0]),
    .done(done_v[0]), .nack(nack_v[0]), .rdata(rdata_v[0]), .scl(scl_v[0]), .sda(sda0)
  );
  i2c_master_ctrl #(.CLK_DIV(2)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(c_valid[1]), .cmd_ready(ready_v[1]),
    .cmd_addr(c_addr[1]), .cmd_rw(c_rw[1]), .cmd_wdata(c_wd[1]), .busy(busy_v[1]),
    .done(done_v[1]), .nack(nack_v[1]), .rdata(rdata_v[1]), .scl(scl_v[1]), .sda(sda1)
  );

  exp_t sbq[$];

  function automatic void chk(string n, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", n, act, exp, cyc);
    end
  endfunction

  function automatic void push(int i, logic nk, logic [7:0] rd, int lat, int cnt, logic [18:0] fr);
    exp_t e;
    e.inst = i; e.nack = nk; e.rdata = rd; e.lat = lat; e.cnt = cnt; e.frame = fr;
    sbq.push_back(e);
  endfunction

  task automatic send(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic hold);
    logic ok;
    @(posedge clk);
    #1;
    c_valid[i] = 1'b1; c_addr[i] = a; c_rw[i] = rw; c_wd[i] = wd;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = ready_v[i];
    end
    acc_done = done_v[i];
    chk("cmd_accepted", ok, 1);
    if (!hold) begin
      @(posedge clk);
      #1 c_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_done(input int i);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = done_v[i];
    end
    chk("done_within_budget", ok, 1);
  endtask

  // Monitor: decodes each bus, plays the slave, and scores every done pulse
  int          cnt[2] = '{0, 0}, run[2] = '{1, 1}, last_cnt[2] = '{0, 0}, acc_cyc[2] = '{0, 0};
  logic [31:0] fr[2] = '{0, 0}, last_fr[2] = '{0, 0};
  logic [1:0]  in_frame = '0, prev_scl = '1, prev_sda = '1;
  initial begin
    logic s, d, legal;
    int   idx;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s = scl_v[i];
        d = sda_v[i];
        if (reset) begin
          in_frame[i] = 1'b0;
          cnt[i] = 0;
          slv_drv[i] = 1'b0;
          run[i] = 1;
        end else begin
          if (s != prev_scl[i]) begin
            if (in_frame[i] && prev_scl[i] && cnt[i] >= 1 && cnt[i] <= 9) chk("scl_high_clks", run[i], i ? 4 : 8);
            if (in_frame[i] && !prev_scl[i] && cnt[i] <= 8) chk("scl_low_clks", run[i], i ? 4 : 8);
            run[i] = 1;
          end else run[i]++;
          if (s && !prev_scl[i]) begin
            cnt[i]++;
            fr[i] = {fr[i][30:0], d};
          end
          if (!s && prev_scl[i] && in_frame[i]) begin
            if (cnt[i] == 8) slv_rw[i] = fr[i][0];
            idx = 16 - cnt[i];
            slv_drv[i] = cnt[i] == 8 ? slv_ack[i] :
                         (cnt[i] >= 9 && cnt[i] <= 16 && slv_rw[i] && slv_ack[i]) ? !slv_data[i][idx[2:0]] :
                         (cnt[i] == 17 && !slv_rw[i] && slv_ack[i]);
          end
          if (s && prev_scl[i] && d != prev_sda[i]) begin
            legal = (!d && !in_frame[i]) || (d && in_frame[i] && (cnt[i] == 10 || cnt[i] == 19));
            chk("sda_stable_while_scl_high", legal, 1);
            if (!d && !in_frame[i]) begin
              in_frame[i] = 1'b1;
              cnt[i] = 0;
              fr[i] = '0;
            end else if (d && in_frame[i]) begin
              in_frame[i] = 1'b0;
              last_cnt[i] = cnt[i];
              last_fr[i] = fr[i];
            end
          end
          if (done_v[i]) begin
            chk("done_expected", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
              e = sbq.pop_front();
              chk("done_instance", i, e.inst);
              chk("nack", nack_v[i], e.nack);
              chk("rdata", rdata_v[i], e.rdata);
              chk("latency", cyc - acc_cyc[i], e.lat);
              chk("bus_scl_pulses", last_cnt[i], e.cnt);
              chk("bus_bits", int'(last_fr[i] & ((32'd1 << e.cnt) - 32'd1)), int'(e.frame));
            end
          end
          if (c_valid[i] && ready_v[i]) acc_cyc[i] = cyc;
        end
        prev_scl[i] = s;
        prev_sda[i] = d;
      end
    end
  end

  // Directed stimulus; expected responses go to the scoreboard before each command
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_scl", scl_v[i], 1);
      chk("rst_sda", sda_v[i], 1);
      chk("rst_ready", ready_v[i], 1);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
      chk("rst_nack", nack_v[i], 0);
      chk("rst_rdata", rdata_v[i], 0);
    end
    reset = 1'b0;
    slv_ack[0] = 1'b1;
    push(0, 1'b0, 8'h00, 321, 19, {8'h54, 1'b0, 8'hA5, 1'b0, 1'b0});
    send(0, 7'h2A, 1'b0, 8'hA5, 1'b0);
    wait_done(0);
    slv_ack[0] = 1'b0;
    push(0, 1'b1, 8'h00, 177, 10, {9'd0, 8'h54, 1'b1, 1'b0});
    send(0, 7'h2A, 1'b0, 8'hA5, 1'b0);
    wait_done(0);
    repeat (10) @(negedge clk);
    chk("scl_idle_after_nack", scl_v[0], 1);
    chk("sda_idle_after_nack", sda_v[0], 1);
    slv_ack[0] = 1'b1;
    slv_data[0] = 8'h3C;
    push(0, 1'b0, 8'h3C, 321, 19, {8'h55, 1'b0, 8'h3C, 1'b1, 1'b0});
    send(0, 7'h2A, 1'b1, 8'hFF, 1'b0);
    wait_done(0);
    slv_ack[0] = 1'b0;
    send(0, 7'h2A, 1'b0, 8'hA5, 1'b0);
    repeat (149) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_scl", scl_v[0], 1);
    chk("abort_sda", sda_v[0], 1);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_ready", ready_v[0], 1);
    chk("abort_rdata", rdata_v[0], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    slv_ack[0] = 1'b1;
    push(0, 1'b0, 8'h00, 321, 19, {8'h54, 1'b0, 8'hA5, 1'b0, 1'b0});
    send(0, 7'h2A, 1'b0, 8'hA5, 1'b0);
    wait_done(0);
    slv_data[0] = 8'hC3;
    push(0, 1'b0, 8'h00, 321, 19, {8'h22, 1'b0, 8'h3C, 1'b0, 1'b0});
    push(0, 1'b0, 8'hC3, 321, 19, {8'h23, 1'b0, 8'hC3, 1'b1, 1'b0});
    send(0, 7'h11, 1'b0, 8'h3C, 1'b1);
    send(0, 7'h11, 1'b1, 8'h00, 1'b0);
    chk("b2b_accept_on_done", acc_done, 1);
    wait_done(0);
    slv_ack[1] = 1'b1;
    push(1, 1'b0, 8'h00, 161, 19, {8'hFE, 1'b0, 8'h00, 1'b0, 1'b0});
    send(1, 7'h7F, 1'b0, 8'h00, 1'b0);
    wait_done(1);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master that sequences transactions on the two-wire bus shared with the team's i2c_slave blocks.
- Accepts one command (7-bit address, R/W, write byte) from a local host over a valid/ready handshake.
- Generates START, the address phase, one data byte, the ACK bits and STOP, then reports read data and NACK status.
- SCL is push-pull. SDA is open-drain: the block drives 0 or releases it, never drives 1.

Parameters:
CLK_DIV, 4, system clocks per SCL quarter-period Q; legal range 2..255; bit time = 4*CLK_DIV clocks

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  host presents a command
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_addr  input  7  target slave address
cmd_rw  input  1  1 = read, 0 = write
cmd_wdata  input  8  byte to write (ignored on read)
busy  output  1  high from accept until done
done  output  1  one-clock pulse when the transaction ends
nack  output  1  status of last transaction; valid with done, held until next accept
rdata  output  8  byte read; valid with done when cmd_rw=1 and nack=0; held until next accept
scl  output  1  bus clock
sda  inout  1  bus data; 0 when drive-low is active, else high-Z

Behaviour:
- Reset values: scl=1, sda released, cmd_ready=1, busy=0, done=0, nack=0, rdata=0, FSM in IDLE, all counters 0.
- Reset mid-transaction takes effect immediately. The bus is released, no STOP is generated, and the FSM returns to IDLE.
- Accept: on cmd_valid && cmd_ready, latch addr, rw and wdata into a shift register {addr,rw}, then wdata. On the next clock cmd_ready=0 and busy=1.
- Timing base: a quarter counter runs 0..CLK_DIV-1, and a phase counter 0..3 advances on each wrap.
- States: IDLE -> START -> ADDR -> ADDR_ACK -> DATA -> DATA_ACK -> STOP -> IDLE.
- START (4Q):
  - q0-q1: scl=1, sda released.
  - q2-q3: scl=1, sda low.
  - Exit with scl going low.
- Data bit (4Q, MSB first, used by ADDR and DATA):
  - q0: scl=0; set sda for this bit (low for 0, release for 1).
  - q1: scl=0.
  - q2-q3: scl=1.
  - Sampling happens on the last clock of q2.
  - SDA changes only while scl=0.
- ADDR: 8 bits of {addr,rw}.
- ADDR_ACK: 1 bit; the master releases SDA.
  - Sampled low: go to DATA.
  - Sampled high: set nack=1 and skip to STOP.
- DATA:
  - Write: shift out wdata.
  - Read: release SDA and shift in on each sample, MSB first, into rdata.
- DATA_ACK:
  - Write: release SDA and sample; nack=1 if high.
  - Read: master sends NACK (SDA released) and nack stays 0.
- STOP (4Q):
  - q0: scl=0, sda low.
  - q1: scl=1, sda low.
  - q2-q3: scl=1, sda released.
- done pulses on the clock after STOP's last quarter. Same edge: busy=0, cmd_ready=1.
- Bit counter is 3 bits and counts 7..0. Exactly 8 bits per byte.
- Latency, accept to done, full transaction: 4 + 9*4 + 9*4 + 4 = 80Q, i.e. 80*CLK_DIV + 1 clocks.
- Latency, address NACK: 4 + 36 + 4 = 44Q, i.e. 44*CLK_DIV + 1 clocks.
- cmd_valid asserted while busy is ignored. The host holds it and it is accepted in IDLE on the clock after done.
- cmd_* inputs are don't-care after accept.
- rdata and nack are updated only on the done edge; nack is cleared at accept.
- On a write, rdata is left unchanged.

Test Plan:
1. CLK_DIV=4, write addr 0x2A, wdata 0xA5, slave ACKs both -> bus bits 0x54 then 0xA5 with START/STOP; nack=0; done exactly 321 clocks after accept.
2. Same write, no slave (SDA pulled up) -> nack=1; no DATA phase; done 177 clocks after accept; SCL idles high afterwards.
3. Read addr 0x2A; bench slave ACKs and drives 0x3C -> rdata=0x3C, nack=0; master SDA released during the ACK bit (NACK).
4. Reset asserted at clock 150 of a write -> scl=1 and sda=Z the same cycle without a clock edge; busy=0, cmd_ready=1; a new command is accepted afterwards and completes normally.
5. Back-to-back commands with cmd_valid held high -> second accept on the clock after done; SDA never changes while SCL=1 except START/STOP edges (assertion over the whole run).
6. CLK_DIV=2, write 0x00 to addr 0x7F -> SCL high and low each 4 clocks; bits 0xFE, 0x00 observed; total 161 clocks.
